vga_timing_gen: RTL and testbench

//   Produces the raster scan that every Sprite/overlay block consumes. Generates

---
 rtl/vga_timing_gen_if.sv | 19 +
 rtl/vga_timing_gen.sv | 121 ++++++++++++
 tb/tb_vga_timing_gen.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: everything a sprite/overlay block needs from the scan.
interface vga_timing_gen_if;
  logic       pix_en;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       video_on;
  logic       hsync;
  logic       vsync;
  logic       line_tick;
  logic       frame_tick;

  modport master (
    output pix_en, pixel_x, pixel_y, video_on, hsync, vsync, line_tick, frame_tick
  );

  modport slave (
    input pix_en, pixel_x, pixel_y, video_on, hsync, vsync, line_tick, frame_tick
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel divider, x/y scan counters and
// registered sync/blank/strobe decode aligned with the counters.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned CLK_DIV  = 2,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  vga_timing_gen_if.master  vga
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [9:0]       X_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]       Y_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]       X_VIS     = 10'(H_ACTIVE);
  localparam logic [9:0]       Y_VIS     = 10'(V_ACTIVE);
  localparam logic [9:0]       HS_FIRST  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]       HS_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0]       VS_FIRST  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]       VS_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt, div_next;
  logic             pix_en;
  logic [9:0]       pixel_x, pixel_y;
  logic [9:0]       x_next, y_next;
  logic             video_on, hsync, vsync, line_tick, frame_tick;
  logic             wrap_x;

  // Divider next value: counts 0..CLK_DIV-1 and wraps.
  always_comb begin
    div_next = div_cnt + 1'b1;
    if (div_cnt == DIV_LAST) begin
      div_next = '0;
    end
  end

  // Next scan position; counters only move on a pixel-enable cycle.
  always_comb begin
    x_next = pixel_x;
    y_next = pixel_y;
    wrap_x = 1'b0;
    if (pix_en) begin
      if (pixel_x == X_LAST) begin
        x_next = '0;
        wrap_x = 1'b1;
        y_next = (pixel_y == Y_LAST) ? '0 : pixel_y + 1'b1;
      end else begin
        x_next = pixel_x + 1'b1;
      end
    end
  end

  // Divider and registered pixel enable (high while div_cnt == CLK_DIV-1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      pix_en  <= 1'b0;
    end else begin
      div_cnt <= div_next;
      pix_en  <= (div_next == DIV_LAST);
    end
  end

  // Scan counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_x <= '0;
      pixel_y <= '0;
    end else begin
      pixel_x <= x_next;
      pixel_y <= y_next;
    end
  end

  // Level decode from the next position so pins line up with the counters;
  // only refreshed on advancing edges, which keeps the first (0,0) blanked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      video_on <= 1'b0;
      hsync    <= ~SYNC_POL;
      vsync    <= ~SYNC_POL;
    end else if (pix_en) begin
      video_on <= (x_next < X_VIS) && (y_next < Y_VIS);
      hsync    <= ((x_next >= HS_FIRST) && (x_next <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
      vsync    <= ((y_next >= VS_FIRST) && (y_next <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
    end
  end

  // One-clk strobes on the advancing edge only; they drop on the next clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_tick  <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      line_tick  <= wrap_x;
      frame_tick <= wrap_x && (y_next == Y_VIS);
    end
  end

  assign vga.pix_en     = pix_en;
  assign vga.pixel_x    = pixel_x;
  assign vga.pixel_y    = pixel_y;
  assign vga.video_on   = video_on;
  assign vga.hsync      = hsync;
  assign vga.vsync      = vsync;
  assign vga.line_tick  = line_tick;
  assign vga.frame_tick = frame_tick;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size 640x480 instance for first-line timing,
// reduced-geometry instances for whole-frame, mid-reset and CLK_DIV=1 cases.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned n_a = 0, n_b = 0, n_c = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if if_a ();
  vga_timing_gen_if if_b ();
  vga_timing_gen_if if_c ();

  vga_timing_gen dut_a (.clk(clk), .rst_n(rst_a), .vga(if_a));

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(4),
    .CLK_DIV(3), .SYNC_POL(1'b0)
  ) dut_b (.clk(clk), .rst_n(rst_b), .vga(if_b));

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(4),
    .CLK_DIV(1), .SYNC_POL(1'b1)
  ) dut_c (.clk(clk), .rst_n(rst_c), .vga(if_c));

  // Clock edges seen since each reset was released.
  always @(posedge clk or negedge rst_a) if (!rst_a) n_a <= 0; else n_a <= n_a + 1;
  always @(posedge clk or negedge rst_b) if (!rst_b) n_b <= 0; else n_b <= n_b + 1;
  always @(posedge clk or negedge rst_c) if (!rst_c) n_c <= 0; else n_c <= n_c + 1;

  // Pixel periods elapsed after n edges: pix_en first shows after edge 1 (D=1)
  // or edge D-1, and each pix_en cycle moves the scan one pixel on the next edge.
  function automatic int unsigned periods(int unsigned n, int unsigned d);
    if (n == 0) return 0;
    if (d == 1) return n - 1;
    return n / d;
  endfunction

  // Expected {pix_en, x, y, video_on, hsync, vsync, line_tick, frame_tick}.
  function automatic logic [25:0] model(int unsigned n,
      int unsigned ha, int unsigned hfp, int unsigned hs, int unsigned hb,
      int unsigned va, int unsigned vfp, int unsigned vs, int unsigned vb,
      int unsigned d, bit pol);
    int unsigned ht, vt, t, x, y;
    bit pe, adv, von, hsy, vsy, lt, ft;
    ht  = ha + hfp + hs + hb;
    vt  = va + vfp + vs + vb;
    pe  = (n >= 1) && ((n % d) == d - 1);
    t   = periods(n, d);
    adv = (n >= 1) && (t != periods(n - 1, d));
    x   = t % ht;
    y   = (t / ht) % vt;
    von = (t != 0) && (x < ha) && (y < va);
    hsy = (x >= ha + hfp && x < ha + hfp + hs) ? pol : !pol;
    vsy = (y >= va + vfp && y < va + vfp + vs) ? pol : !pol;
    lt  = adv && (x == 0);
    ft  = lt && (y == va);
    return {pe, 10'(x), 10'(y), von, hsy, vsy, lt, ft};
  endfunction

  function automatic logic [25:0] exp_a(int unsigned n);
    return model(n, 640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0);
  endfunction
  function automatic logic [25:0] exp_b(int unsigned n);
    return model(n, 16, 4, 6, 6, 12, 2, 2, 4, 3, 1'b0);
  endfunction
  function automatic logic [25:0] exp_c(int unsigned n);
    return model(n, 16, 4, 6, 6, 12, 2, 2, 4, 1, 1'b1);
  endfunction

  wire [25:0] obs_a = {if_a.pix_en, if_a.pixel_x, if_a.pixel_y, if_a.video_on,
                       if_a.hsync, if_a.vsync, if_a.line_tick, if_a.frame_tick};
  wire [25:0] obs_b = {if_b.pix_en, if_b.pixel_x, if_b.pixel_y, if_b.video_on,
                       if_b.hsync, if_b.vsync, if_b.line_tick, if_b.frame_tick};
  wire [25:0] obs_c = {if_c.pix_en, if_c.pixel_x, if_c.pixel_y, if_c.video_on,
                       if_c.hsync, if_c.vsync, if_c.line_tick, if_c.frame_tick};

  localparam logic [25:0] RST_LOW  = {1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam logic [25:0] RST_HIGH = {1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (obs_a !== RST_LOW) begin
      errors++; $display("FAIL reset_a got %h exp %h", obs_a, RST_LOW);
    end
    checks++;
    if (obs_b !== RST_LOW) begin
      errors++; $display("FAIL reset_b got %h exp %h", obs_b, RST_LOW);
    end
    checks++;
    if (obs_c !== RST_HIGH) begin
      errors++; $display("FAIL reset_c got %h exp %h", obs_c, RST_HIGH);
    end
  endtask

  // Two full 640-wide lines at CLK_DIV=2 plus spot checks on the line wrap.
  task automatic test_first_line();
    logic [25:0] e;
    rst_a = 1'b1;
    for (int unsigned k = 0; k < 3300; k++) begin
      @(negedge clk);
      e = exp_a(n_a);
      checks++;
      if (obs_a !== e) begin
        errors++;
        if (errors < 20) $display("FAIL scan_a n=%0d got %h exp %h", n_a, obs_a, e);
      end
      if (n_a == 2 || n_a == 1598 || n_a == 1600 || n_a == 1312 || n_a == 1504) begin
        checks++;
        if (n_a == 2 && if_a.pixel_x !== 10'd1) begin
          errors++; $display("FAIL x_at_2 got %0d exp 1", if_a.pixel_x);
        end else if (n_a == 1598 && if_a.pixel_x !== 10'd799) begin
          errors++; $display("FAIL x_at_1598 got %0d exp 799", if_a.pixel_x);
        end else if (n_a == 1600 && {if_a.pixel_x, if_a.pixel_y, if_a.line_tick} !== {10'd0, 10'd1, 1'b1}) begin
          errors++; $display("FAIL wrap_1600 got x=%0d y=%0d lt=%b exp x=0 y=1 lt=1",
                             if_a.pixel_x, if_a.pixel_y, if_a.line_tick);
        end else if (n_a == 1312 && if_a.hsync !== 1'b0) begin
          errors++; $display("FAIL hsync_656 got %b exp 0", if_a.hsync);
        end else if (n_a == 1504 && if_a.hsync !== 1'b1) begin
          errors++; $display("FAIL hsync_752 got %b exp 1", if_a.hsync);
        end
      end
    end
    rst_a = 1'b0;
  endtask

  // Three reduced frames: cycle-exact scan, frame spacing and visible count.
  task automatic test_frames();
    logic [25:0] e;
    int unsigned last_ft = 0, von_cnt = 0;
    bit seen_ft = 1'b0;
    rst_b = 1'b1;
    for (int unsigned k = 0; k < 32 * 20 * 3 * 3 + 50; k++) begin
      @(negedge clk);
      e = exp_b(n_b);
      checks++;
      if (obs_b !== e) begin
        errors++;
        if (errors < 20) $display("FAIL scan_b n=%0d got %h exp %h", n_b, obs_b, e);
      end
      if (if_b.pix_en && if_b.video_on) von_cnt++;
      if (if_b.frame_tick) begin
        if (seen_ft) begin
          checks++;
          if (n_b - last_ft != 32 * 20 * 3) begin
            errors++; $display("FAIL frame_gap got %0d exp %0d", n_b - last_ft, 32 * 20 * 3);
          end
          checks++;
          if (von_cnt != 16 * 12) begin
            errors++; $display("FAIL visible_count got %0d exp %0d", von_cnt, 16 * 12);
          end
        end
        seen_ft = 1'b1;
        last_ft = n_b;
        von_cnt = 0;
      end
    end
    checks++;
    if (!seen_ft) begin
      errors++; $display("FAIL frame_tick_seen got 0 exp 1");
    end
  endtask

  // Asynchronous resets at random points plus one at a fixed mid-frame pixel.
  task automatic test_mid_reset();
    logic [25:0] e;
    int unsigned budget;
    for (int unsigned r = 0; r < 5; r++) begin
      if (r == 0) begin
        budget = 0;
        while (!(if_b.pixel_x == 10'd20 && if_b.pixel_y == 10'd10) && budget < 4000) begin
          @(negedge clk);
          budget++;
        end
        checks++;
        if (budget >= 4000) begin
          errors++; $display("FAIL reach_20_10 got timeout exp position");
        end
      end else begin
        for (int unsigned k = 0; k < $urandom_range(40, 1900); k++) begin
          @(negedge clk);
          e = exp_b(n_b);
          checks++;
          if (obs_b !== e) begin
            errors++;
            if (errors < 20) $display("FAIL mid_scan_b n=%0d got %h exp %h", n_b, obs_b, e);
          end
        end
      end
      #($urandom_range(1, 3));
      rst_b = 1'b0;
      #1;
      checks++;
      if (obs_b !== RST_LOW) begin
        errors++; $display("FAIL async_reset_b got %h exp %h", obs_b, RST_LOW);
      end
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rst_b = 1'b1;
      for (int unsigned k = 0; k < 200; k++) begin
        @(negedge clk);
        e = exp_b(n_b);
        checks++;
        if (obs_b !== e) begin
          errors++;
          if (errors < 20) $display("FAIL restart_b n=%0d got %h exp %h", n_b, obs_b, e);
        end
      end
    end
    rst_b = 1'b0;
  endtask

  // CLK_DIV=1 with active-high sync: two frames, line strobes every 32 clks.
  task automatic test_div1_pol1();
    logic [25:0] e;
    int unsigned last_lt = 0;
    bit seen_lt = 1'b0;
    rst_c = 1'b1;
    for (int unsigned k = 0; k < 32 * 20 * 2 + 40; k++) begin
      @(negedge clk);
      e = exp_c(n_c);
      checks++;
      if (obs_c !== e) begin
        errors++;
        if (errors < 20) $display("FAIL scan_c n=%0d got %h exp %h", n_c, obs_c, e);
      end
      if (if_c.line_tick) begin
        if (seen_lt) begin
          checks++;
          if (n_c - last_lt != 32) begin
            errors++; $display("FAIL line_gap_c got %0d exp 32", n_c - last_lt);
          end
        end
        seen_lt = 1'b1;
        last_lt = n_c;
      end
    end
    rst_c = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_line();
    test_frames();
    test_mid_reset();
    test_div1_pol1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
